// File: rtl/reg_wb_queue.sv
// Register writeback queue: a small circular FIFO of pending {addr, data}
// register-file writes. It drains one entry per cycle when the register-file
// write port is free, and offers a combinational bypass lookup on two read
// addresses that returns the newest pending value for a register.
module reg_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              flush,
  input  logic              rf_stall,
  output logic              write_enable1,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] lu_addr1,
  input  logic [ADDR_W-1:0] lu_addr2,
  output logic              lu_hit1,
  output logic              lu_hit2,
  output logic [DATA_W-1:0] lu_data1,
  output logic [DATA_W-1:0] lu_data2,
  output logic [CNT_W-1:0]  count
);

  // Entry storage; validity is implied by head/count, so it is never reset.
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;

  logic not_empty;
  logic push;
  logic pop;

  // Ready depends only on occupancy, never on whether a drain happens this cycle.
  assign wb_ready      = (count_reg != CNT_W'(DEPTH));
  assign not_empty     = (count_reg != '0);
  assign write_enable1 = not_empty && !rf_stall;
  assign push          = wb_valid && wb_ready && !flush;
  assign pop           = write_enable1 && !flush;

  assign write_addr = not_empty ? addr_mem[head_reg] : '0;
  assign write_data = not_empty ? data_mem[head_reg] : '0;
  assign count      = count_reg;

  // Pointer and occupancy update; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + PTR_W'(1);
      if (pop)  head_reg <= head_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Store an accepted request at the tail slot.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      addr_mem[tail_reg] <= wb_addr;
      data_mem[tail_reg] <= wb_data;
    end
  end

  // Bypass lookup, one instance per read port. Entries are scanned from
  // oldest to newest so the last match (closest to tail) wins.
  logic [ADDR_W-1:0] lu_addr_arr [2];
  assign lu_addr_arr[0] = lu_addr1;
  assign lu_addr_arr[1] = lu_addr2;

  for (genvar gi = 0; gi < 2; gi++) begin : gen_lu
    logic              hit;
    logic [DATA_W-1:0] data;
    logic [PTR_W-1:0]  idx;

    // Newest-match search over the currently pending entries only.
    always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
        idx = head_reg + PTR_W'(k);
        if ((CNT_W'(k) < count_reg) && (addr_mem[idx] == lu_addr_arr[gi])) begin
          hit  = 1'b1;
          data = data_mem[idx];
        end
      end
    end
  end

  assign lu_hit1  = gen_lu[0].hit;
  assign lu_data1 = gen_lu[0].data;
  assign lu_hit2  = gen_lu[1].hit;
  assign lu_data2 = gen_lu[1].data;

endmodule

// File: tb/tb_reg_wb_queue.sv
// Self-checking bench for reg_wb_queue: a queue-based reference model tracks
// pending writes; a negedge monitor compares every DUT output against it.
module tb_reg_wb_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ready;
  logic              flush;
  logic              rf_stall;
  logic              write_enable1;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] lu_addr1;
  logic [ADDR_W-1:0] lu_addr2;
  logic              lu_hit1;
  logic              lu_hit2;
  logic [DATA_W-1:0] lu_data1;
  logic [DATA_W-1:0] lu_data2;
  logic [CNT_W-1:0]  count;

  reg_wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .flush(flush), .rf_stall(rf_stall),
    .write_enable1(write_enable1), .write_addr(write_addr), .write_data(write_data),
    .lu_addr1(lu_addr1), .lu_addr2(lu_addr2),
    .lu_hit1(lu_hit1), .lu_hit2(lu_hit2), .lu_data1(lu_data1), .lu_data2(lu_data2),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t exp_q[$];       // pending writes, oldest at index 0
  bit   chk_en = 1'b0;
  int   n_cmp  = 0;
  int   n_err  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Newest pending entry for an address, straight from the queue contents.
  function automatic void ref_lookup(input logic [ADDR_W-1:0] a, output bit h,
                                     output logic [DATA_W-1:0] d);
    h = 1'b0;
    d = '0;
    for (int i = 0; i < exp_q.size(); i++)
      if (exp_q[i].a == a) begin
        h = 1'b1;
        d = exp_q[i].d;
      end
  endfunction

  // Reference model: applies this edge's reset/flush/write/accept to the queue.
  bit acc;
  bit wr;
  always @(posedge clk) begin
    if (!rst) begin
      exp_q.delete();
      chk_en = 1'b1;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      acc = wb_valid && (exp_q.size() < DEPTH);
      wr  = (exp_q.size() != 0) && !rf_stall;
      if (wr) begin
        $display("write addr=%0d data=%08h", exp_q[0].a, exp_q[0].d);
        void'(exp_q.pop_front());
      end
      if (acc) exp_q.push_back({wb_addr, wb_data});
    end
  end

  // Monitor: compares all outputs against the model away from the active edge.
  always @(negedge clk) begin
    int n;
    bit h;
    logic [DATA_W-1:0] d;
    if (chk_en) begin
      n = exp_q.size();
      chk("count", count, n);
      chk("wb_ready", wb_ready, n != DEPTH);
      chk("write_enable1", write_enable1, (n != 0) && !rf_stall);
      if (n != 0) begin
        chk("write_addr", write_addr, exp_q[0].a);
        chk("write_data", write_data, exp_q[0].d);
      end else begin
        chk("write_addr_idle", write_addr, 0);
        chk("write_data_idle", write_data, 0);
      end
      ref_lookup(lu_addr1, h, d);
      chk("lu_hit1", lu_hit1, h);
      chk("lu_data1", lu_data1, d);
      ref_lookup(lu_addr2, h, d);
      chk("lu_hit2", lu_hit2, h);
      chk("lu_data2", lu_data2, d);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    rst = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    flush = 1'b0; rf_stall = 1'b0; lu_addr1 = '0; lu_addr2 = '0;
    tick(); tick();
    rst = 1'b1;
    @(negedge clk);
    chk("reset_ready", wb_ready, 1);
    chk("reset_we", write_enable1, 0);
    tick();

    // Single write with one-cycle latency.
    wb_valid = 1'b1; wb_addr = 4'd3; wb_data = 32'h2;
    tick();
    idle();
    @(negedge clk);
    chk("single_we", write_enable1, 1);
    chk("single_addr", write_addr, 3);
    chk("single_data", write_data, 32'h2);
    tick();
    @(negedge clk);
    chk("single_done_we", write_enable1, 0);
    chk("single_done_cnt", count, 0);
    tick();

    // Bypass returns the newest of two entries for the same register.
    rf_stall = 1'b1;
    wb_valid = 1'b1; wb_addr = 4'd11; wb_data = 32'h5; tick();
    wb_addr = 4'd11; wb_data = 32'h7; tick();
    idle(); lu_addr1 = 4'd11; lu_addr2 = 4'd4;
    @(negedge clk);
    chk("bypass_hit1", lu_hit1, 1);
    chk("bypass_data1", lu_data1, 32'h7);
    chk("bypass_hit2", lu_hit2, 0);
    chk("bypass_data2", lu_data2, 0);
    flush = 1'b1; tick(); idle();

    // Fill under stall; the fifth request must be dropped.
    for (int i = 1; i <= 5; i++) begin
      wb_valid = 1'b1; wb_addr = ADDR_W'(i); wb_data = $urandom;
      tick();
    end
    idle();
    @(negedge clk);
    chk("fill_count", count, DEPTH);
    chk("fill_ready", wb_ready, 0);
    rf_stall = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    chk("fill_drained", count, 0);

    // Streaming with push and pop in the same cycle across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      wb_valid = 1'b1; wb_addr = ADDR_W'(i); wb_data = $urandom;
      tick();
      @(negedge clk);
      chk("stream_cnt_le1", count <= 1, 1);
    end
    idle(); tick(); tick();

    // Flush with a concurrent request: nothing survives.
    rf_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wb_valid = 1'b1; wb_addr = ADDR_W'(i + 6); wb_data = $urandom; tick();
    end
    flush = 1'b1; wb_valid = 1'b1; wb_addr = 4'd9; wb_data = 32'hdead;
    tick();
    idle(); rf_stall = 1'b0;
    @(negedge clk);
    chk("flush_count", count, 0);
    chk("flush_we", write_enable1, 0);
    tick();

    // Reset mid-operation discards pending entries.
    rf_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wb_valid = 1'b1; wb_addr = ADDR_W'(i + 12); wb_data = $urandom; tick();
    end
    idle(); rst = 1'b0; tick();
    rst = 1'b1; rf_stall = 1'b0;
    @(negedge clk);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_we", write_enable1, 0);
    chk("rst_mid_ready", wb_ready, 1);
    tick(); tick();

    // Randomised traffic with occasional flush and reset.
    for (int c = 0; c < 800; c++) begin
      wb_valid = ($urandom_range(0, 99) < 60);
      wb_addr  = ADDR_W'($urandom_range(0, 7));
      wb_data  = $urandom;
      rf_stall = ($urandom_range(0, 99) < 35);
      flush    = ($urandom_range(0, 99) < 3);
      rst      = !($urandom_range(0, 99) < 1);
      lu_addr1 = ADDR_W'($urandom_range(0, 7));
      lu_addr2 = ADDR_W'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b1; idle(); rf_stall = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/reg_wb_queue.md
REG_WB_QUEUE -- requirements
Module: reg_wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of pending-write entries; power of two, 2..16.
REQ-002 Parameter DATA_W, default 32, register data width.
REQ-003 Parameter ADDR_W, default 4, register address width (16 registers).
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 wb_valid  input  1  writeback request from execute stage.
REQ-008 wb_addr  input  ADDR_W  destination register of request.
REQ-009 wb_data  input  DATA_W  result to be written.
REQ-010 wb_ready  output  1  queue accepts a request this cycle.
REQ-011 flush  input  1  discard all pending entries.
REQ-012 rf_stall  input  1  register-file write port unavailable this cycle.
REQ-013 write_enable1  output  1  write strobe to register file.
REQ-014 write_addr  output  ADDR_W  register-file write address.
REQ-015 write_data  output  DATA_W  register-file write data.
REQ-016 lu_addr1, lu_addr2  input  ADDR_W each  bypass lookup addresses (from read_addr1/read_addr2).
REQ-017 lu_hit1, lu_hit2  output  1 each  a pending entry matches the lookup address.
REQ-018 lu_data1, lu_data2  output  DATA_W each  data of newest matching pending entry.
REQ-019 count  output  log2(DEPTH)+1  number of pending entries.

Function
REQ-020 The block SHALL hold pending writes in a circular FIFO of DEPTH entries {addr, data} with head/tail pointers that wrap modulo DEPTH.
REQ-021 wb_ready SHALL equal (count != DEPTH) and SHALL NOT depend on same-cycle drain.
REQ-022 Push SHALL occur on a rising edge when wb_valid && wb_ready && !flush; wb_valid while !wb_ready SHALL be ignored and not stored.
REQ-023 write_enable1 SHALL be combinational: (count != 0) && !rf_stall; write_addr/write_data SHALL show the head entry whenever count != 0, else zero.
REQ-024 Pop SHALL occur on a rising edge when write_enable1 is high and flush is low.
REQ-025 Entries SHALL drain in acceptance order; duplicate addresses SHALL each be written, oldest first.
REQ-026 Minimum latency SHALL be one cycle: request accepted at edge N drives write_enable1 in cycle N+1.
REQ-027 Simultaneous push and pop SHALL leave count unchanged, both pointers advance.
REQ-028 flush SHALL set count, head, tail to 0 on the next edge, overriding push and pop; write_enable1 SHALL still be driven combinationally in the flush cycle.
REQ-029 lu_hitN SHALL be high iff some pending entry has addr == lu_addrN; lu_dataN SHALL be that newest (closest to tail) entry's data, else zero.
REQ-030 Lookup SHALL be combinational over stored entries only; a same-cycle wb_* request SHALL NOT produce a hit.
REQ-031 rf_stall held high SHALL retain all entries; queue fills and wb_ready drops at count == DEPTH.

Reset
REQ-032 With rst low at a rising edge: count=0, head=tail=0, stored entries treated invalid; from the next cycle wb_ready=1, write_enable1=0, write_addr=0, write_data=0, lu_hit1=lu_hit2=0, lu_data1=lu_data2=0.
REQ-033 Reset SHALL take priority over flush, push and pop; pending entries at reset SHALL be lost, never written.

Verification
REQ-034 Single write: push {addr=3, data=0x2}, rf_stall=0 -> next cycle write_enable1=1, write_addr=3, write_data=0x2; following cycle count=0, write_enable1=0.
REQ-035 Fill/backpressure: rf_stall=1, push 5 requests addr 1..5 -> first 4 accepted, count=4, wb_ready=0, 5th ignored; release stall -> writes addr 1,2,3,4 on 4 consecutive cycles.
REQ-036 Bypass priority: rf_stall=1, push {11,0x5} then {11,0x7}; lu_addr1=11, lu_addr2=4 -> lu_hit1=1, lu_data1=0x7, lu_hit2=0, lu_data2=0.
REQ-037 Wrap-around: DEPTH=4, stream 10 requests with simultaneous push/pop -> write order identical to push order, count never exceeds 1, no drop.
REQ-038 Flush: 3 entries pending, flush=1 with wb_valid=1 -> next cycle count=0, write_enable1=0, new request not stored.
REQ-039 Reset mid-operation: 2 entries pending, rst=0 for one edge -> all outputs at REQ-032 values, no further write_enable1 until a new push.
